// File: rtl/issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_scheduler_if
// Purpose  : Decode/CDB/release inputs and allocation outputs of the issue stage.
// Revision : 1.0
// ============================================================================
interface issue_scheduler_if #(
  parameter int RS_PER_FU = 2,
  parameter int TAG_W     = 3
);
  logic                     id_is_valid;
  logic [1:0]               id_is_fununit;
  logic [1:0]               id_is_numop;
  logic [4:0]               id_is_addra;
  logic [4:0]               id_is_addrb;
  logic [4:0]               id_is_regdest;
  logic                     id_is_writereg;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic                     rs_release_valid;
  logic [TAG_W-1:0]         rs_release_tag;
  logic                     is_if_stall;
  logic                     is_alloc_valid;
  logic [TAG_W-1:0]         is_alloc_tag;
  logic                     is_qj_pend;
  logic [TAG_W-1:0]         is_qj;
  logic                     is_qk_pend;
  logic [TAG_W-1:0]         is_qk;
  logic [3*RS_PER_FU-1:0]   is_rs_busy;

  modport master (
    output id_is_valid, id_is_fununit, id_is_numop, id_is_addra, id_is_addrb,
           id_is_regdest, id_is_writereg, cdb_valid, cdb_tag,
           rs_release_valid, rs_release_tag,
    input  is_if_stall, is_alloc_valid, is_alloc_tag, is_qj_pend, is_qj,
           is_qk_pend, is_qk, is_rs_busy
  );

  modport slave (
    input  id_is_valid, id_is_fununit, id_is_numop, id_is_addra, id_is_addrb,
           id_is_regdest, id_is_writereg, cdb_valid, cdb_tag,
           rs_release_valid, rs_release_tag,
    output is_if_stall, is_alloc_valid, is_alloc_tag, is_qj_pend, is_qj,
           is_qk_pend, is_qk, is_rs_busy
  );
endinterface
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : issue_scheduler
// Purpose  : Allocates reservation-station slots and resolves operand tags.
// Revision : 1.0
// ============================================================================
module issue_scheduler #(
  parameter int RS_PER_FU = 2,
  parameter int TAG_W     = 3
) (
  input  logic               clock,
  input  logic               reset,
  issue_scheduler_if.slave   bus
);

  localparam int NUM_SLOTS = 3 * RS_PER_FU;
  localparam int NUM_REGS  = 32;

  logic [NUM_SLOTS-1:0] rs_busy_q, rs_busy_d;
  logic [NUM_REGS-1:0]  rst_busy_q, rst_busy_d;
  logic [TAG_W-1:0]     rst_tag_q [NUM_REGS];
  logic [TAG_W-1:0]     rst_tag_d [NUM_REGS];

  logic                 alloc_valid_q, alloc_valid_d;
  logic [TAG_W-1:0]     alloc_tag_q, alloc_tag_d;
  logic                 qj_pend_q, qj_pend_d;
  logic [TAG_W-1:0]     qj_q, qj_d;
  logic                 qk_pend_q, qk_pend_d;
  logic [TAG_W-1:0]     qk_q, qk_d;

  logic                 unit_req;
  logic                 slot_found;
  logic [TAG_W-1:0]     slot_tag;
  logic                 issue;
  logic                 use_a, use_b;
  logic [TAG_W-1:0]     tag_a, tag_b;
  logic                 pend_a, pend_b;

  // Descending scan so the last match is the lowest free slot of the unit.
  always_comb begin : slot_search
    unit_req   = bus.id_is_valid && (bus.id_is_fununit != 2'd3);
    slot_found = 1'b0;
    slot_tag   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (((s / RS_PER_FU) == int'(bus.id_is_fununit)) && !rs_busy_q[s]) begin
        slot_found = 1'b1;
        slot_tag   = TAG_W'(s);
      end
    end
    issue = unit_req && slot_found;
  end

  assign bus.is_if_stall = unit_req && !slot_found;

  // A CDB hit on the producer tag makes the operand ready in the same cycle.
  always_comb begin : operand_lookup
    use_a  = (bus.id_is_numop != 2'd0) && (bus.id_is_addra != 5'd0);
    use_b  = (bus.id_is_numop == 2'd2) && (bus.id_is_addrb != 5'd0);
    tag_a  = use_a ? rst_tag_q[bus.id_is_addra] : '0;
    tag_b  = use_b ? rst_tag_q[bus.id_is_addrb] : '0;
    pend_a = use_a && rst_busy_q[bus.id_is_addra] &&
             !(bus.cdb_valid && (bus.cdb_tag == tag_a));
    pend_b = use_b && rst_busy_q[bus.id_is_addrb] &&
             !(bus.cdb_valid && (bus.cdb_tag == tag_b));
  end

  always_comb begin : next_state
    rs_busy_d = rs_busy_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (bus.rs_release_valid && (bus.rs_release_tag == TAG_W'(s))) begin
        rs_busy_d[s] = 1'b0;
      end
      if (issue && (slot_tag == TAG_W'(s))) begin
        rs_busy_d[s] = 1'b1;
      end
    end

    rst_busy_d = rst_busy_q;
    rst_tag_d  = rst_tag_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.cdb_valid && rst_busy_q[r] && (rst_tag_q[r] == bus.cdb_tag)) begin
        rst_busy_d[r] = 1'b0;
      end
    end
    // Applied after the CDB clear so a same-cycle rename keeps the register busy.
    if (issue && bus.id_is_writereg && (bus.id_is_regdest != 5'd0)) begin
      rst_busy_d[bus.id_is_regdest] = 1'b1;
      rst_tag_d[bus.id_is_regdest]  = slot_tag;
    end

    alloc_valid_d = issue;
    alloc_tag_d   = issue ? slot_tag : '0;
    qj_pend_d     = issue && pend_a;
    qj_d          = issue ? tag_a : '0;
    qk_pend_d     = issue && pend_b;
    qk_d          = issue ? tag_b : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_busy_q     <= '0;
      rst_busy_q    <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        rst_tag_q[r] <= '0;
      end
      alloc_valid_q <= 1'b0;
      alloc_tag_q   <= '0;
      qj_pend_q     <= 1'b0;
      qj_q          <= '0;
      qk_pend_q     <= 1'b0;
      qk_q          <= '0;
    end else begin
      rs_busy_q     <= rs_busy_d;
      rst_busy_q    <= rst_busy_d;
      rst_tag_q     <= rst_tag_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_tag_q   <= alloc_tag_d;
      qj_pend_q     <= qj_pend_d;
      qj_q          <= qj_d;
      qk_pend_q     <= qk_pend_d;
      qk_q          <= qk_d;
    end
  end

  assign bus.is_alloc_valid = alloc_valid_q;
  assign bus.is_alloc_tag   = alloc_tag_q;
  assign bus.is_qj_pend     = qj_pend_q;
  assign bus.is_qj          = qj_q;
  assign bus.is_qk_pend     = qk_pend_q;
  assign bus.is_qk          = qk_q;
  assign bus.is_rs_busy     = rs_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scheduler
// Purpose  : Directed bench for issue_scheduler with a reference model.
// Revision : 1.0
// ============================================================================
module tb_issue_scheduler;

  localparam int RS_PER_FU = 2;
  localparam int TAG_W     = 3;
  localparam int NUM_SLOTS = 3 * RS_PER_FU;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   started  = 1'b0;

  issue_scheduler_if #(.RS_PER_FU(RS_PER_FU), .TAG_W(TAG_W)) bus ();

  issue_scheduler #(.RS_PER_FU(RS_PER_FU), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: slot occupancy, register rename table, expected outputs.
  bit m_rs       [NUM_SLOTS];
  bit m_reg_busy [32];
  int m_reg_tag  [32];
  bit e_alloc_valid;
  int e_alloc_tag;
  bit e_qj_pend;
  int e_qj;
  bit e_qk_pend;
  int e_qk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_free(input int fu);
    if (fu > 2) return -1;
    for (int s = 0; s < RS_PER_FU; s++) begin
      if (!m_rs[fu * RS_PER_FU + s]) return fu * RS_PER_FU + s;
    end
    return -1;
  endfunction

  function automatic bit op_pend(input int addr, input bit used);
    if (!used || addr == 0) return 1'b0;
    return m_reg_busy[addr] && !(bus.cdb_valid && int'(bus.cdb_tag) == m_reg_tag[addr]);
  endfunction

  function automatic int op_tag(input int addr, input bit used);
    return (used && addr != 0) ? m_reg_tag[addr] : 0;
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int pick;
    int fu;
    bit ua;
    bit ub;
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) m_rs[s] = 1'b0;
      for (int r = 0; r < 32; r++) begin
        m_reg_busy[r] = 1'b0;
        m_reg_tag[r]  = 0;
      end
      e_alloc_valid = 1'b0; e_alloc_tag = 0;
      e_qj_pend = 1'b0; e_qj = 0; e_qk_pend = 1'b0; e_qk = 0;
    end else begin
      fu   = int'(bus.id_is_fununit);
      pick = bus.id_is_valid ? first_free(fu) : -1;
      ua   = bus.id_is_numop >= 2'd1;
      ub   = bus.id_is_numop == 2'd2;
      e_alloc_valid = (pick >= 0);
      e_alloc_tag   = (pick >= 0) ? pick : 0;
      e_qj_pend     = (pick >= 0) && op_pend(int'(bus.id_is_addra), ua);
      e_qj          = (pick >= 0) ? op_tag(int'(bus.id_is_addra), ua) : 0;
      e_qk_pend     = (pick >= 0) && op_pend(int'(bus.id_is_addrb), ub);
      e_qk          = (pick >= 0) ? op_tag(int'(bus.id_is_addrb), ub) : 0;
      if (bus.cdb_valid) begin
        for (int r = 0; r < 32; r++) begin
          if (m_reg_busy[r] && m_reg_tag[r] == int'(bus.cdb_tag)) m_reg_busy[r] = 1'b0;
        end
      end
      if (bus.rs_release_valid && int'(bus.rs_release_tag) < NUM_SLOTS)
        m_rs[int'(bus.rs_release_tag)] = 1'b0;
      if (pick >= 0) begin
        m_rs[pick] = 1'b1;
        if (bus.id_is_writereg && bus.id_is_regdest != 5'd0) begin
          m_reg_busy[int'(bus.id_is_regdest)] = 1'b1;
          m_reg_tag[int'(bus.id_is_regdest)]  = pick;
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    int fu;
    logic [31:0] busy_vec;
    if (started && !reset) begin
      fu = int'(bus.id_is_fununit);
      chk("stall", 32'(bus.is_if_stall),
          32'(bus.id_is_valid && fu != 3 && first_free(fu) < 0));
      chk("alloc_valid", 32'(bus.is_alloc_valid), 32'(e_alloc_valid));
      chk("alloc_tag",   32'(bus.is_alloc_tag),   32'(e_alloc_tag));
      chk("qj_pend",     32'(bus.is_qj_pend),     32'(e_qj_pend));
      chk("qj",          32'(bus.is_qj),          32'(e_qj));
      chk("qk_pend",     32'(bus.is_qk_pend),     32'(e_qk_pend));
      chk("qk",          32'(bus.is_qk),          32'(e_qk));
      busy_vec = '0;
      for (int s = 0; s < NUM_SLOTS; s++) busy_vec[s] = m_rs[s];
      chk("rs_busy", 32'(bus.is_rs_busy), busy_vec);
    end
  end

  task automatic idle();
    bus.id_is_valid      = 1'b0;
    bus.id_is_fununit    = 2'd0;
    bus.id_is_numop      = 2'd0;
    bus.id_is_addra      = 5'd0;
    bus.id_is_addrb      = 5'd0;
    bus.id_is_regdest    = 5'd0;
    bus.id_is_writereg   = 1'b0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_tag          = '0;
    bus.rs_release_valid = 1'b0;
    bus.rs_release_tag   = '0;
  endtask

  task automatic issue_op(input int fu, input int numop, input int ra, input int rb,
                          input int rd, input bit wr);
    bus.id_is_valid    = 1'b1;
    bus.id_is_fununit  = 2'(fu);
    bus.id_is_numop    = 2'(numop);
    bus.id_is_addra    = 5'(ra);
    bus.id_is_addrb    = 5'(rb);
    bus.id_is_regdest  = 5'(rd);
    bus.id_is_writereg = wr;
  endtask

  task automatic release_slot(input int tag);
    bus.rs_release_valid = 1'b1;
    bus.rs_release_tag   = TAG_W'(tag);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("lit_reset_busy",  32'(bus.is_rs_busy),     32'h0);
    chk("lit_reset_alloc", 32'(bus.is_alloc_valid), 32'h0);
    reset   = 1'b0;
    started = 1'b1;

    // First ALU issue writing r5
    issue_op(0, 0, 0, 0, 5, 1'b1);
    tick();
    chk("lit_first_valid", 32'(bus.is_alloc_valid), 32'h1);
    chk("lit_first_tag",   32'(bus.is_alloc_tag),   32'h0);
    chk("lit_first_busy",  32'(bus.is_rs_busy),     32'h01);
    idle();
    tick();
    chk("lit_pulse_once", 32'(bus.is_alloc_valid), 32'h0);
    release_slot(0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd0;
    tick();
    idle();

    // Three ALU issues back to back; third stalls, release lifts it next cycle
    issue_op(0, 0, 0, 0, 1, 1'b0);
    tick();
    chk("lit_b2b_tag0", 32'(bus.is_alloc_tag), 32'h0);
    tick();
    chk("lit_b2b_tag1", 32'(bus.is_alloc_tag), 32'h1);
    release_slot(1);
    #1;
    chk("lit_stall_hold", 32'(bus.is_if_stall), 32'h1);
    tick();
    chk("lit_stall_noalloc", 32'(bus.is_alloc_valid), 32'h0);
    bus.rs_release_valid = 1'b0;
    #1;
    chk("lit_stall_clear", 32'(bus.is_if_stall), 32'h0);
    tick();
    chk("lit_third_valid", 32'(bus.is_alloc_valid), 32'h1);
    chk("lit_third_tag",   32'(bus.is_alloc_tag),   32'h1);
    idle();
    release_slot(0); tick();
    release_slot(1); tick();
    idle();

    // Producer of r5 on the shift unit, then a dependent consumer
    issue_op(1, 0, 0, 0, 5, 1'b1);
    tick();
    chk("lit_prod_tag", 32'(bus.is_alloc_tag), 32'h2);
    issue_op(0, 2, 5, 0, 0, 1'b0);
    tick();
    chk("lit_cons_qj_pend", 32'(bus.is_qj_pend), 32'h1);
    chk("lit_cons_qj",      32'(bus.is_qj),      32'h2);
    chk("lit_cons_qk_pend", 32'(bus.is_qk_pend), 32'h0);

    // Consumer in the same cycle as the producer's broadcast
    issue_op(0, 1, 5, 0, 0, 1'b0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd2;
    tick();
    chk("lit_bypass_pend", 32'(bus.is_qj_pend),   32'h0);
    chk("lit_bypass_tag",  32'(bus.is_alloc_tag), 32'h1);
    idle();
    release_slot(0); tick();
    release_slot(1); tick();
    idle();
    issue_op(0, 1, 5, 0, 0, 1'b0);
    tick();
    chk("lit_r5_cleared", 32'(bus.is_qj_pend), 32'h0);

    // Broadcast of the old r5 producer while a new producer renames r5
    idle();
    release_slot(2); tick();
    idle();
    issue_op(1, 0, 0, 0, 5, 1'b1);
    tick();
    issue_op(2, 0, 0, 0, 5, 1'b1);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd2;
    tick();
    chk("lit_rename_tag", 32'(bus.is_alloc_tag), 32'h4);
    idle();
    issue_op(0, 1, 5, 0, 0, 1'b0);
    tick();
    chk("lit_rename_pend", 32'(bus.is_qj_pend), 32'h1);
    chk("lit_rename_qj",   32'(bus.is_qj),      32'h4);

    // NOP, invalid-tag release and release of an idle slot
    idle();
    issue_op(3, 2, 5, 5, 7, 1'b1);
    #1;
    chk("lit_nop_stall", 32'(bus.is_if_stall), 32'h0);
    tick();
    chk("lit_nop_alloc", 32'(bus.is_alloc_valid), 32'h0);
    idle();
    release_slot(7); tick();
    release_slot(3); tick();
    idle();

    // Fill every slot, then reset mid-stream
    issue_op(1, 2, 5, 6, 6, 1'b1);
    tick();
    issue_op(2, 1, 6, 0, 7, 1'b1);
    tick();
    chk("lit_full_busy", 32'(bus.is_rs_busy), 32'h3F);
    issue_op(0, 0, 0, 0, 0, 1'b0);
    #1;
    chk("lit_full_stall", 32'(bus.is_if_stall), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("lit_mid_reset_busy",  32'(bus.is_rs_busy),     32'h0);
    chk("lit_mid_reset_valid", 32'(bus.is_alloc_valid), 32'h0);
    chk("lit_mid_reset_tag",   32'(bus.is_alloc_tag),   32'h0);
    chk("lit_mid_reset_stall", 32'(bus.is_if_stall),    32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    issue_op(2, 1, 5, 0, 0, 1'b0);
    tick();
    chk("lit_post_reset_tag",  32'(bus.is_alloc_tag), 32'h4);
    chk("lit_post_reset_pend", 32'(bus.is_qj_pend),   32'h0);
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
